param_stack: RTL and testbench
==============================

// Module: param_stack
// PURPOSE
//  Parametrised LIFO for KGP-RISC: call/return-address and spill storage.
//  Generalises the fixed 32x64 stack with configurable width and depth.
//  Adds full/empty/count status, sticky overflow/underflow errors and a same-cycle push+pop (replace-top) mode.
//  Sits beside the register file; driven by the control unit on CALL/RET/PUSH/POP.
// PARAMETERS
//  DATA_W  32  word width in bits
//  DEPTH   64  number of entries; any integer >= 2
//  AW      $clog2(DEPTH)  localparam; pointer width. Count width is AW+1.
// PORTS
//  clk        in   1       single clock; all state updates on rising edge
//  reset      in   1       asynchronous, active-high; clears all state immediately
//  push       in   1       request: write data_in on top of stack
//  pop        in   1       request: remove top entry and return it on data_out
//  data_in    in   DATA_W  push data
//  err_clr    in   1       clears the sticky overflow and underflow flags
//  data_out   out  DATA_W  popped word; registered
//  out_valid  out  1       1-cycle pulse; data_out carries a popped word
//  top        out  DATA_W  combinational peek at mem[count-1]; 0 when empty
//  count      out  AW+1    occupancy, 0..DEPTH
//  full       out  1       count == DEPTH
//  empty      out  1       count == 0
//  overflow   out  1       sticky: a push was rejected
//  underflow  out  1       sticky: a pop was rejected
// BEHAVIOUR
//  Reset values: count=0, data_out=0, out_valid=0, overflow=0, underflow=0.
//   Memory contents are not cleared. Reset asserted mid-operation aborts any in-flight pop;
//   out_valid is 0 in the cycle after release.
//  Pointer: count is also the write address. Valid entries are mem[0..count-1].
//  Decode per cycle (P=push, Q=pop):
//   P & ~Q, not full:  mem[count] <= data_in; count+1
//   P & ~Q, full:      push dropped; memory and count unchanged; overflow <= 1
//   Q & ~P, not empty: data_out <= mem[count-1]; out_valid <= 1; count-1
//   Q & ~P, empty:     pop dropped; out_valid <= 0; data_out holds; underflow <= 1
//   P & Q, not empty:  replace top. data_out <= old mem[count-1]; mem[count-1] <= data_in;
//                      out_valid <= 1; count unchanged. Legal when full.
//   P & Q, empty:      pop fails (underflow <= 1, out_valid <= 0); push proceeds;
//                      mem[0] <= data_in; count=1
//   idle:              out_valid <= 0; data_out holds its last value
//  Latency: pop data is on data_out exactly 1 cycle after the pop edge.
//   top reflects a push in the cycle after that push's edge.
//  No pointer wrap: count saturates at 0 and DEPTH; errors are flagged instead.
//  full and empty are decoded combinationally from the count register.
//  err_clr: clears both sticky flags at the edge. If a new error occurs in the same cycle,
//   the set wins.
//  Non-power-of-2 DEPTH: the addresses used are always < DEPTH.
// STRUCTURE
//  Shared package/header kgp_stack_pkg: STACK_DATA_W and STACK_DEPTH defaults, plus an
//   enumerated op code {OP_IDLE, OP_PUSH, OP_POP, OP_REPL} used by this block and the control unit.
//  Sub-module stack_ram: DEPTH x DATA_W register array
//   - one synchronous write port
//   - one asynchronous read port (shared by top and the pop path)
//  Top level holds the op decode, count register, flags and the data_out/out_valid registers.
// TESTING
//  1 Reset then 3 pushes (0xA1, 0xB2, 0xC3) -> count=3, top=0xC3, empty=0, full=0
//  2 Pop x3 after test 1 -> data_out 0xC3, 0xB2, 0xA1 on consecutive cycles, out_valid=1 each;
//    then empty=1, count=0
//  3 Pop on empty -> underflow=1, out_valid=0, count=0
//    Then err_clr -> underflow=0; err_clr together with a bad pop -> underflow stays 1
//  4 DEPTH=4: 5 pushes -> full after 4th; 5th dropped, overflow=1; top = 4th value
//  5 Stack holding [0x11, 0x22], push=pop=1, data_in=0x33 -> data_out=0x22, out_valid=1,
//    count=2, top=0x33; repeat when full -> count stays DEPTH, no overflow
//  6 Reset asserted asynchronously between edges during a pop burst -> outputs clear
//    immediately; count=0 and no out_valid after release

Source files
------------

// File: rtl/kgp_stack_pkg.sv
// kgp_stack_pkg: shared definitions for the KGP-RISC stack and the control
// unit that drives it.
//   STACK_DATA_W / STACK_DEPTH : default word width and entry count
//   stack_op_e                 : per-cycle stack operation
//   decode_op()                : maps the push/pop request pair onto stack_op_e
package kgp_stack_pkg;

  localparam int STACK_DATA_W = 32;
  localparam int STACK_DEPTH  = 64;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_REPL = 2'b11
  } stack_op_e;

  function automatic stack_op_e decode_op(input logic push, input logic pop);
    stack_op_e op;
    case ({push, pop})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = OP_REPL;
      default: op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/param_stack_if.sv
// param_stack_if: request/response bundle between the control unit (master)
// and the stack (slave).
//   push, pop, data_in, err_clr        : master -> stack requests
//   data_out, out_valid                : registered pop result
//   top, count, full, empty            : occupancy / peek status
//   overflow, underflow                : sticky error flags
interface param_stack_if
  import kgp_stack_pkg::*;
#(
  parameter int DATA_W = STACK_DATA_W,
  parameter int DEPTH  = STACK_DEPTH
) ();

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              push;
  logic              pop;
  logic [DATA_W-1:0] data_in;
  logic              err_clr;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic [DATA_W-1:0] top;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, pop, data_in, err_clr,
    input  data_out, out_valid, top, count, full, empty, overflow, underflow
  );

  modport slave (
    input  push, pop, data_in, err_clr,
    output data_out, out_valid, top, count, full, empty, overflow, underflow
  );

endinterface

// File: rtl/stack_ram.sv
// stack_ram: DEPTH x DATA_W register array, no reset on contents.
//   clk           : write clock
//   we/waddr/wdata: synchronous write port
//   raddr/rdata   : asynchronous read port
module stack_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_stack.sv
// param_stack: parametrised LIFO for call/return addresses and spills.
//   clk   : rising-edge clock
//   reset : asynchronous active-high clear of count, data_out, out_valid, flags
//   bus   : param_stack_if slave (push/pop/data_in/err_clr in; pop result,
//           top peek, count, full/empty and sticky overflow/underflow out)
// count doubles as the write address; valid entries are mem[0..count-1].
module param_stack
  import kgp_stack_pkg::*;
#(
  parameter int DATA_W = STACK_DATA_W,
  parameter int DEPTH  = STACK_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  param_stack_if.slave  bus
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);

  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              out_valid_q, out_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              is_full, is_empty;
  logic [AW:0]       count_m1;
  logic [AW-1:0]     top_addr;
  logic              ram_we;
  logic [AW-1:0]     ram_waddr;
  logic [DATA_W-1:0] ram_rdata;
  stack_op_e         op;

  assign is_full  = (count_q == FULL_CNT);
  assign is_empty = (count_q == '0);
  assign count_m1 = count_q - CNT_ONE;
  // Park the read address at 0 when empty so it never leaves 0..DEPTH-1.
  assign top_addr = is_empty ? '0 : count_m1[AW-1:0];
  assign op       = decode_op(bus.push, bus.pop);

  stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (bus.data_in),
    .raddr (top_addr),
    .rdata (ram_rdata)
  );

  always_comb begin
    count_d     = count_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    // err_clr drops the flags; any error this cycle re-sets them below.
    overflow_d  = overflow_q  & ~bus.err_clr;
    underflow_d = underflow_q & ~bus.err_clr;
    ram_we      = 1'b0;
    ram_waddr   = top_addr;

    case (op)
      OP_PUSH: begin
        if (is_full) begin
          overflow_d = 1'b1;
        end else begin
          ram_we    = 1'b1;
          ram_waddr = count_q[AW-1:0];
          count_d   = count_q + CNT_ONE;
        end
      end
      OP_POP: begin
        if (is_empty) begin
          underflow_d = 1'b1;
        end else begin
          data_out_d  = ram_rdata;
          out_valid_d = 1'b1;
          count_d     = count_m1;
        end
      end
      OP_REPL: begin
        ram_we = 1'b1;
        if (is_empty) begin
          // The pop half fails, the push half still lands at entry 0.
          underflow_d = 1'b1;
          ram_waddr   = '0;
          count_d     = CNT_ONE;
        end else begin
          // Old top is read combinationally before the same-edge overwrite.
          data_out_d  = ram_rdata;
          out_valid_d = 1'b1;
          ram_waddr   = top_addr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.top       = is_empty ? '0 : ram_rdata;
  assign bus.count     = count_q;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_param_stack.sv
module tb_param_stack;

  localparam int DW = 16;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  param_stack_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

  param_stack #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the stack as a queue, back = top of stack.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout;
  logic          m_ov, m_ovf, m_udf;

  function automatic logic [DW-1:0] m_top();
    return (mq.size() == 0) ? '0 : mq[mq.size()-1];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_dout = '0; m_ov = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic model_step(input logic p, input logic q, input logic [DW-1:0] d, input logic ec);
    m_ov = 0;
    if (ec) begin m_ovf = 0; m_udf = 0; end
    if (p && !q) begin
      if (mq.size() == DP) m_ovf = 1; else mq.push_back(d);
    end else if (q && !p) begin
      if (mq.size() == 0) m_udf = 1;
      else begin m_dout = mq.pop_back(); m_ov = 1; end
    end else if (p && q) begin
      if (mq.size() == 0) begin m_udf = 1; mq.push_back(d); end
      else begin m_dout = mq[mq.size()-1]; mq[mq.size()-1] = d; m_ov = 1; end
    end
  endtask

  // Drive one cycle; returns 1 time unit after the rising edge.
  task automatic drive(input logic p, input logic q, input logic [DW-1:0] d, input logic ec);
    bus.push = p; bus.pop = q; bus.data_in = d; bus.err_clr = ec;
    @(posedge clk);
    #1;
    model_step(p, q, d, ec);
    bus.push = 0; bus.pop = 0; bus.err_clr = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.push = 0; bus.pop = 0; bus.err_clr = 0; bus.data_in = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    n_cmp++; if (bus.data_out !== 16'h0) begin n_bad++; $display("FAIL reset_dout got %0h exp 0", bus.data_out); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ov got %0b exp 0", bus.out_valid); end
    n_cmp++; if ({bus.overflow, bus.underflow} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b exp 00", {bus.overflow, bus.underflow}); end
    n_cmp++; if ({bus.empty, bus.full} !== 2'b10) begin n_bad++; $display("FAIL reset_empty_full got %b exp 10", {bus.empty, bus.full}); end
    n_cmp++; if (bus.top !== 16'h0) begin n_bad++; $display("FAIL reset_top got %0h exp 0", bus.top); end
  endtask

  task automatic test_push3();
    drive(1, 0, 16'hA1, 0);
    n_cmp++; if (bus.top !== 16'hA1) begin n_bad++; $display("FAIL push1_top got %0h exp a1", bus.top); end
    drive(1, 0, 16'hB2, 0);
    drive(1, 0, 16'hC3, 0);
    n_cmp++; if (bus.count !== 3'd3) begin n_bad++; $display("FAIL push3_count got %0d exp 3", bus.count); end
    n_cmp++; if (bus.top !== 16'hC3) begin n_bad++; $display("FAIL push3_top got %0h exp c3", bus.top); end
    n_cmp++; if ({bus.empty, bus.full} !== 2'b00) begin n_bad++; $display("FAIL push3_empty_full got %b exp 00", {bus.empty, bus.full}); end
  endtask

  task automatic test_pop3();
    logic [DW-1:0] exp_v [3];
    exp_v[0] = 16'hC3; exp_v[1] = 16'hB2; exp_v[2] = 16'hA1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, '0, 0);
      n_cmp++; if (bus.data_out !== exp_v[i]) begin n_bad++; $display("FAIL pop%0d_dout got %0h exp %0h", i, bus.data_out, exp_v[i]); end
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL pop%0d_ov got %0b exp 1", i, bus.out_valid); end
    end
    n_cmp++; if (bus.empty !== 1'b1 || bus.count !== 3'd0) begin n_bad++; $display("FAIL pop3_empty got empty=%0b count=%0d exp 1/0", bus.empty, bus.count); end
  endtask

  task automatic test_underflow();
    drive(0, 1, '0, 0);
    n_cmp++; if (bus.underflow !== 1'b1) begin n_bad++; $display("FAIL udf_set got %0b exp 1", bus.underflow); end
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin n_bad++; $display("FAIL udf_ov_count got ov=%0b count=%0d exp 0/0", bus.out_valid, bus.count); end
    n_cmp++; if (bus.data_out !== 16'hA1) begin n_bad++; $display("FAIL udf_dout_hold got %0h exp a1", bus.data_out); end
    drive(0, 0, '0, 1);
    n_cmp++; if (bus.underflow !== 1'b0) begin n_bad++; $display("FAIL udf_clr got %0b exp 0", bus.underflow); end
    drive(0, 1, '0, 1);
    n_cmp++; if (bus.underflow !== 1'b1) begin n_bad++; $display("FAIL udf_set_wins got %0b exp 1", bus.underflow); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 16'h100 + 16'(i), 0);
      if (i == 3) begin
        n_cmp++; if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_full4 got full=%0b ovf=%0b exp 1/0", bus.full, bus.overflow); end
      end
    end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %0b exp 1", bus.overflow); end
    n_cmp++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL ovf_count got %0d exp 4", bus.count); end
    n_cmp++; if (bus.top !== 16'h103) begin n_bad++; $display("FAIL ovf_top got %0h exp 103", bus.top); end
  endtask

  task automatic test_replace();
    do_reset();
    drive(1, 0, 16'h11, 0);
    drive(1, 0, 16'h22, 0);
    drive(1, 1, 16'h33, 0);
    n_cmp++; if (bus.data_out !== 16'h22 || bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL repl_dout got %0h/%0b exp 22/1", bus.data_out, bus.out_valid); end
    n_cmp++; if (bus.count !== 3'd2 || bus.top !== 16'h33) begin n_bad++; $display("FAIL repl_state got count=%0d top=%0h exp 2/33", bus.count, bus.top); end
    drive(1, 0, 16'h44, 0);
    drive(1, 0, 16'h55, 0);
    drive(1, 1, 16'h66, 0);
    n_cmp++; if (bus.count !== 3'd4 || bus.overflow !== 1'b0) begin n_bad++; $display("FAIL repl_full got count=%0d ovf=%0b exp 4/0", bus.count, bus.overflow); end
    n_cmp++; if (bus.data_out !== 16'h55 || bus.top !== 16'h66) begin n_bad++; $display("FAIL repl_full_data got dout=%0h top=%0h exp 55/66", bus.data_out, bus.top); end
    do_reset();
    drive(1, 1, 16'h77, 0);
    n_cmp++; if (bus.count !== 3'd1 || bus.top !== 16'h77 || bus.underflow !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL repl_empty got count=%0d top=%0h udf=%0b ov=%0b exp 1/77/1/0", bus.count, bus.top, bus.underflow, bus.out_valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1, 0, 16'hD1, 0);
    drive(1, 0, 16'hD2, 0);
    drive(1, 0, 16'hD3, 0);
    drive(0, 1, '0, 0);
    bus.pop = 1;
    #3;
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.data_out !== 16'h0) begin
      n_bad++; $display("FAIL arst_immediate got count=%0d ov=%0b dout=%0h exp 0/0/0", bus.count, bus.out_valid, bus.data_out);
    end
    @(posedge clk);
    #2;
    bus.pop = 0;
    reset = 1'b0;
    model_reset();
    drive(0, 0, '0, 0);
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.underflow !== 1'b0) begin
      n_bad++; $display("FAIL arst_release got ov=%0b count=%0d udf=%0b exp 0/0/0", bus.out_valid, bus.count, bus.underflow);
    end
  endtask

  task automatic test_random();
    logic p, q, ec;
    logic [DW-1:0] d;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      p  = ($urandom_range(0, 99) < 50);
      q  = ($urandom_range(0, 99) < 45);
      ec = ($urandom_range(0, 99) < 8);
      d  = DW'($urandom);
      drive(p, q, d, ec);
      n_cmp++;
      if (bus.count !== ($bits(bus.count))'(mq.size()) || bus.top !== m_top() ||
          bus.out_valid !== m_ov || (m_ov && bus.data_out !== m_dout) ||
          bus.data_out !== m_dout || bus.overflow !== m_ovf || bus.underflow !== m_udf ||
          bus.full !== (mq.size() == DP) || bus.empty !== (mq.size() == 0)) begin
        n_bad++;
        $display("FAIL rand[%0d] got cnt=%0d top=%0h dout=%0h ov=%0b ovf=%0b udf=%0b exp cnt=%0d top=%0h dout=%0h ov=%0b ovf=%0b udf=%0b",
                 i, bus.count, bus.top, bus.data_out, bus.out_valid, bus.overflow, bus.underflow,
                 mq.size(), m_top(), m_dout, m_ov, m_ovf, m_udf);
      end
    end
  endtask

  initial begin
    bus.push = 0; bus.pop = 0; bus.err_clr = 0; bus.data_in = '0;
    test_reset();
    test_push3();
    test_pop3();
    test_underflow();
    test_overflow();
    test_replace();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
